// File: rtl/serial_cmd_framer.sv
// Serial command framer: parses SYNC/payload/checksum frames into a wide command word
// and queues ACK/NAK plus host response bytes into a paced TX FIFO.
module serial_cmd_framer #(
    parameter int         PAYLOAD_BYTES  = 3,
    parameter int         TX_DEPTH       = 8,
    parameter int         TIMEOUT_CYCLES = 65535,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15
) (
    input  logic                       clk_dot4x,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_new_data,
    output logic [8*PAYLOAD_BYTES-1:0] cmd_data,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    input  logic [7:0]                 host_tx_data,
    input  logic                       host_tx_push,
    output logic                       host_tx_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_new_data,
    input  logic                       tx_busy,
    output logic [7:0]                 err_count
);

    localparam int CMD_W = 8 * PAYLOAD_BYTES;
    localparam int IDX_W = $clog2(PAYLOAD_BYTES) + 1;
    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = $clog2(TX_DEPTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TX_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK,
        HOLD
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [7:0]         sum_reg;
    logic [CMD_W-1:0]   asm_reg;
    logic [CMD_W-1:0]   cmd_data_reg;
    logic               cmd_valid_reg;
    logic [TO_W-1:0]    to_cnt_reg;
    logic [7:0]         err_count_reg;

    logic [7:0]         tx_mem [TX_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [7:0]         tx_data_reg;
    logic               tx_new_data_reg;

    logic               resp_req;
    logic               sum_ok;
    logic [7:0]         resp_byte;
    logic               fifo_full;
    logic               pop;
    logic               resp_drop;
    logic               wr_en;
    logic [7:0]         wr_byte;
    logic               in_frame;
    logic               timeout_hit;
    logic               err_event;

    // The checksum strobe doubles as the ACK/NAK write request, so it preempts host pushes.
    assign resp_req      = (state_reg == CHECK) && rx_new_data;
    assign sum_ok        = (rx_data == sum_reg);
    assign resp_byte     = sum_ok ? ACK_BYTE : NAK_BYTE;
    assign fifo_full     = (count_reg == FULL_CNT);
    assign pop           = (count_reg != '0) && !tx_busy && !tx_new_data_reg;
    assign resp_drop     = resp_req && fifo_full && !pop;
    assign host_tx_ready = !fifo_full && !resp_req;
    assign wr_en         = resp_req ? !resp_drop : (host_tx_push && host_tx_ready);
    assign wr_byte       = resp_req ? resp_byte : host_tx_data;

    assign in_frame    = (state_reg == PAYLOAD) || (state_reg == CHECK);
    assign timeout_hit = in_frame && !rx_new_data && (to_cnt_reg == TO_LIMIT);
    assign err_event   = (resp_req && !sum_ok) || timeout_hit ||
                         ((state_reg == HOLD) && rx_new_data) || resp_drop;

    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            sum_reg       <= '0;
            asm_reg       <= '0;
            cmd_data_reg  <= '0;
            cmd_valid_reg <= 1'b0;
            to_cnt_reg    <= '0;
            err_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rx_new_data && (rx_data == SYNC_BYTE)) begin
                        state_reg  <= PAYLOAD;
                        idx_reg    <= '0;
                        sum_reg    <= '0;
                        to_cnt_reg <= '0;
                    end
                end
                PAYLOAD: begin
                    if (rx_new_data) begin
                        asm_reg    <= (asm_reg << 8) | CMD_W'(rx_data);
                        sum_reg    <= sum_reg + rx_data;
                        idx_reg    <= idx_reg + 1'b1;
                        to_cnt_reg <= '0;
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= CHECK;
                        end
                    end else if (timeout_hit) begin
                        state_reg <= IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                CHECK: begin
                    if (rx_new_data) begin
                        to_cnt_reg <= '0;
                        if (sum_ok) begin
                            cmd_data_reg  <= asm_reg;
                            cmd_valid_reg <= 1'b1;
                            state_reg     <= HOLD;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        state_reg <= IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (cmd_valid_reg && cmd_ready) begin
                        cmd_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (err_event && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 1'b1;
            end
        end
    end

    // FIFO storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk_dot4x) begin
        if (wr_en) begin
            tx_mem[wr_ptr_reg] <= wr_byte;
        end
    end

    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            tx_data_reg     <= '0;
            tx_new_data_reg <= 1'b0;
        end else begin
            tx_new_data_reg <= pop;
            if (pop) begin
                tx_data_reg <= tx_mem[rd_ptr_reg];
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            end
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign cmd_data    = cmd_data_reg;
    assign cmd_valid   = cmd_valid_reg;
    assign tx_data     = tx_data_reg;
    assign tx_new_data = tx_new_data_reg;
    assign err_count   = err_count_reg;

endmodule

// File: tb/tb_serial_cmd_framer.sv
// Bench for serial_cmd_framer: directed scenarios then random frames, checked against
// expectations derived from frame contents (payload concat, byte-sum checksum, error tallies).
module tb_serial_cmd_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_new_data = 1'b0;
    logic [23:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [7:0]  host_tx_data = 8'h00;
    logic        host_tx_push = 1'b0;
    logic        host_tx_ready;
    logic [7:0]  tx_data;
    logic        tx_new_data;
    logic        tx_busy = 1'b0;
    logic [7:0]  err_count;

    serial_cmd_framer #(
        .PAYLOAD_BYTES (3),
        .TX_DEPTH      (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_dot4x    (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_new_data  (rx_new_data),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .host_tx_data (host_tx_data),
        .host_tx_push (host_tx_push),
        .host_tx_ready(host_tx_ready),
        .tx_data      (tx_data),
        .tx_new_data  (tx_new_data),
        .tx_busy      (tx_busy),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_err = 0;
    logic [7:0]  exp_tx[$];
    logic [23:0] exp_cmd[$];

    // Observed traffic, collected on the falling edge.
    int cyc = 0;
    int last_strobe = -100;
    int spacing_bad = 0;
    logic [7:0]  tx_q[$];
    logic [23:0] cmd_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_new_data) begin
                if (cyc - last_strobe < 2) spacing_bad <= spacing_bad + 1;
                last_strobe <= cyc;
                tx_q.push_back(tx_data);
            end
            if (cmd_valid && cmd_ready) cmd_q.push_back(cmd_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_new_data = 1'b1;
        @(posedge clk);
        #1;
        rx_new_data = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(p0);
        send_byte(p1);
        send_byte(p2);
        send_byte(cs);
    endtask

    task automatic push_host(input logic [7:0] b);
        host_tx_data = b;
        host_tx_push = 1'b1;
        @(posedge clk);
        #1;
        host_tx_push = 1'b0;
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for an edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_data", 32'(cmd_data), 32'd0);
        check("rst_tx_new_data", 32'(tx_new_data), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_host_tx_ready", 32'(host_tx_ready), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_err = 0;
    endtask

    task automatic check_queues(input string tag);
        check({tag, "_tx_len"}, 32'(tx_q.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
            check({tag, "_tx_byte"}, 32'(tx_q[i]), 32'(exp_tx[i]));
        check({tag, "_cmd_len"}, 32'(cmd_q.size()), 32'(exp_cmd.size()));
        for (int i = 0; i < exp_cmd.size() && i < cmd_q.size(); i++)
            check({tag, "_cmd_word"}, 32'(cmd_q[i]), 32'(exp_cmd[i]));
        check({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
        check({tag, "_tx_spacing"}, 32'(spacing_bad), 32'd0);
    endtask

    initial begin
        logic [7:0] p[3];
        logic [7:0] hb[4];
        logic [7:0] b;
        logic [7:0] sum;
        logic [7:0] cs;
        int kind;
        int k;

        // Good frame with exact cmd_valid timing.
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        rx_data = 8'h9C;
        rx_new_data = 1'b1;
        #1;
        check("good_ready_blocked_by_ack", 32'(host_tx_ready), 32'd0);
        check("good_valid_before", 32'(cmd_valid), 32'd0);
        @(posedge clk);
        #1;
        rx_new_data = 1'b0;
        check("good_valid_rise", 32'(cmd_valid), 32'd1);
        check("good_cmd_data", 32'(cmd_data), 32'h123456);
        idle(1);
        check("good_valid_fall", 32'(cmd_valid), 32'd0);
        exp_cmd.push_back(24'h123456);
        exp_tx.push_back(8'h06);
        idle(6);
        check_queues("good");

        // Bad checksum, then a good frame.
        do_reset();
        send_frame(8'h01, 8'h02, 8'h03, 8'h07);
        check("bad_no_valid", 32'(cmd_valid), 32'd0);
        exp_tx.push_back(8'h15);
        exp_err = 1;
        send_frame(8'h01, 8'h02, 8'h03, 8'h06);
        exp_tx.push_back(8'h06);
        exp_cmd.push_back(24'h010203);
        idle(8);
        check_queues("badsum");

        // Back-pressure with overrun bytes in HOLD.
        do_reset();
        cmd_ready = 1'b0;
        send_frame(8'h01, 8'h02, 8'h03, 8'h06);
        exp_tx.push_back(8'h06);
        send_byte(8'hA5);
        send_byte(8'h01);
        exp_err = 2;
        idle(3);
        check("bp_valid_held", 32'(cmd_valid), 32'd1);
        check("bp_data_held", 32'(cmd_data), 32'h010203);
        check("bp_err", 32'(err_count), 32'd2);
        cmd_ready = 1'b1;
        exp_cmd.push_back(24'h010203);
        idle(1);
        check("bp_valid_cleared", 32'(cmd_valid), 32'd0);
        send_frame(8'h0A, 8'h0B, 8'h0C, 8'h21);
        exp_tx.push_back(8'h06);
        exp_cmd.push_back(24'h0A0B0C);
        idle(8);
        check_queues("backpressure");

        // Inter-byte timeout, then boundary gaps of TIMEOUT_CYCLES-1 idle cycles.
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h11);
        idle(100);
        exp_err = 1;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        idle(8);
        check_queues("timeout");
        send_byte(8'hA5);
        idle(99);
        send_byte(8'h01);
        idle(99);
        send_byte(8'h02);
        idle(99);
        send_byte(8'h03);
        idle(99);
        send_byte(8'h06);
        exp_tx.push_back(8'h06);
        exp_cmd.push_back(24'h010203);
        idle(8);
        check_queues("timeout_edge");

        // TX FIFO full: ACK is dropped, host bytes drain in order.
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hb[i] = 8'($urandom_range(0, 255));
            check("fifo_ready_before_push", 32'(host_tx_ready), 32'd1);
            push_host(hb[i]);
        end
        check("fifo_full_ready", 32'(host_tx_ready), 32'd0);
        push_host(8'hEE);
        send_frame(8'h01, 8'h02, 8'h03, 8'h06);
        exp_cmd.push_back(24'h010203);
        exp_err = 1;
        idle(3);
        check("fifo_drop_err", 32'(err_count), 32'd1);
        tx_busy = 1'b0;
        for (int i = 0; i < 4; i++) exp_tx.push_back(hb[i]);
        idle(20);
        check_queues("fifo_full");

        // Reset while holding a command and a queued ACK, then mid-frame.
        do_reset();
        cmd_ready = 1'b0;
        tx_busy = 1'b1;
        send_frame(8'h12, 8'h34, 8'h56, 8'h9C);
        send_byte(8'h77);
        check("pre_rst_valid", 32'(cmd_valid), 32'd1);
        check("pre_rst_err", 32'(err_count), 32'd1);
        do_reset();
        tx_busy = 1'b0;
        cmd_ready = 1'b1;
        idle(10);
        send_byte(8'hA5);
        send_byte(8'h12);
        do_reset();
        send_frame(8'h12, 8'h34, 8'h56, 8'h9C);
        exp_tx.push_back(8'h06);
        exp_cmd.push_back(24'h123456);
        idle(10);
        check_queues("midframe_reset");

        // err_count saturation via overruns in HOLD.
        do_reset();
        cmd_ready = 1'b0;
        send_frame(8'h01, 8'h02, 8'h03, 8'h06);
        exp_tx.push_back(8'h06);
        repeat (254) send_byte(8'($urandom_range(0, 255)));
        check("sat_254", 32'(err_count), 32'd254);
        send_byte(8'h00);
        check("sat_255", 32'(err_count), 32'd255);
        repeat (3) send_byte(8'hA5);
        check("sat_hold", 32'(err_count), 32'd255);
        cmd_ready = 1'b1;
        exp_cmd.push_back(24'h010203);
        idle(4);

        // Random frames: good, bad checksum, timeout, good followed by overrun.
        do_reset();
        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b);
                idle(int'($urandom_range(0, 3)));
            end
            send_byte(8'hA5);
            idle(int'($urandom_range(0, 3)));
            k = (kind == 2) ? int'($urandom_range(0, 3)) : 3;
            for (int i = 0; i < 3; i++) p[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < k; i++) begin
                send_byte(p[i]);
                idle(int'($urandom_range(0, 3)));
            end
            if (kind == 2) begin
                idle(100 + int'($urandom_range(0, 5)));
                exp_err++;
            end else begin
                sum = p[0] + p[1] + p[2];
                cs = (kind == 1) ? sum + 8'($urandom_range(1, 255)) : sum;
                send_byte(cs);
                if (kind == 1) begin
                    exp_tx.push_back(8'h15);
                    exp_err++;
                    idle(int'($urandom_range(0, 2)));
                end else begin
                    exp_tx.push_back(8'h06);
                    exp_cmd.push_back({p[0], p[1], p[2]});
                    if (kind == 3) begin
                        send_byte(8'hA5);
                        exp_err++;
                    end
                    idle(int'($urandom_range(1, 3)));
                end
            end
        end
        idle(20);
        check_queues("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
